// File: rtl/instr_fetch_unit_if.sv
// rtl/instr_fetch_unit_if.sv - instruction memory request/response bundle
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC/fetch stage: imem handshake, instruction hold, next-PC select
module instr_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  imem,
  output logic [31:0]         instr,
  output logic [6:0]          opcode,
  output logic                instr_valid,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  input  logic                retire,
  input  logic                branch,
  input  logic                jump,
  input  logic                zero,
  input  logic [XLEN-1:0]     pc_target,
  output logic                misalign,
  output logic [31:0]         retired_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            misalign_q, misalign_d;
  logic [31:0]     count_q, count_d;
  logic            taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      count_q       <= count_d;
    end
  end

  // Responses outside S_WAIT and retires outside S_HOLD fall through untouched.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = 1'b0;
    count_d       = count_q;
    taken         = jump | (branch & zero);
    case (state_q)
      S_REQ: begin
        if (imem.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rsp_valid) begin
          state_d       = S_HOLD;
          instr_d       = imem.imem_rdata;
          instr_valid_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (retire) begin
          state_d       = S_REQ;
          pc_d          = taken ? {pc_target[XLEN-1:2], 2'b00} : pc_plus4;
          instr_valid_d = 1'b0;
          count_d       = count_q + 32'd1;
          misalign_d    = taken & (pc_target[1:0] != 2'b00);
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  assign imem.imem_req_valid = (state_q == S_REQ) && !rst;
  assign imem.imem_addr      = pc_q;
  assign instr               = instr_q;
  assign opcode              = instr_q[6:0];
  assign instr_valid         = instr_valid_q;
  assign pc                  = pc_q;
  assign pc_plus4            = pc_q + XLEN'(4);
  assign misalign            = misalign_q;
  assign retired_count       = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - table vectors, reset corner sequences and randomized fetch/retire checks
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc, pc_plus4;
  logic        retire, branch, jump, zero;
  logic [31:0] pc_target;
  logic        misalign;
  logic [31:0] retired_count;

  int n_vec = 0;
  int n_err = 0;

  instr_fetch_unit_if #(.XLEN(32)) bus ();

  instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (bus),
    .instr         (instr),
    .opcode        (opcode),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .retire        (retire),
    .branch        (branch),
    .jump          (jump),
    .zero          (zero),
    .pc_target     (pc_target),
    .misalign      (misalign),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] rdata;
    int          rdy_dly;
    int          rsp_dly;
    logic        br, jp, zr;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic [6:0]  exp_op;
    logic [31:0] exp_next;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_txn(input logic [31:0] rdata, input int rdy_dly, input int rsp_dly,
                        input int hold_dly, input logic br, input logic jp, input logic zr,
                        input logic [31:0] tgt, input logic [31:0] exp_pc,
                        input logic [6:0] exp_op, input logic [31:0] exp_next,
                        input logic exp_mis, input logic [31:0] exp_cnt);
    int guard = 0;
    while (!bus.imem_req_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("imem_addr", bus.imem_addr, exp_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'($urandom_range(0, 1));
      bus.imem_rdata     = $urandom;
      @(negedge clk);
      chk("req_hold_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("req_hold_addr", bus.imem_addr, exp_pc);
    end
    bus.imem_rsp_valid = 1'b0;
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < rsp_dly; i++) begin
      retire = 1'b1; branch = 1'b1; jump = 1'b1; zero = 1'b1; pc_target = $urandom;
      @(negedge clk);
      chk("wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("wait_instr_valid", 32'(instr_valid), 32'd0);
    end
    retire = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rdata     = rdata;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rdata     = $urandom;
    chk("instr_valid", 32'(instr_valid), 32'd1);
    chk("instr", instr, rdata);
    chk("opcode", 32'(opcode), 32'(exp_op));
    chk("pc", pc, exp_pc);
    chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
    chk("count_before", retired_count, exp_cnt - 32'd1);
    for (int i = 0; i < hold_dly; i++) begin
      branch = 1'($urandom); jump = 1'($urandom); zero = 1'($urandom); pc_target = $urandom;
      @(negedge clk);
      chk("hold_instr", instr, rdata);
    end
    branch = br; jump = jp; zero = zr; pc_target = tgt; retire = 1'b1;
    @(negedge clk);
    retire = 1'b0;
    branch = 1'($urandom); jump = 1'($urandom); zero = 1'($urandom); pc_target = $urandom;
    chk("misalign", 32'(misalign), 32'(exp_mis));
    chk("post_instr_valid", 32'(instr_valid), 32'd0);
    chk("post_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("next_addr", bus.imem_addr, exp_next);
    chk("retired_count", retired_count, exp_cnt);
    @(negedge clk);
    chk("misalign_pulse_end", 32'(misalign), 32'd0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd1);
    chk({tag, "_addr"}, bus.imem_addr, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_count"}, retired_count, 32'd0);
    chk({tag, "_misalign"}, 32'(misalign), 32'd0);
  endtask

  logic [31:0] m_pc, m_cnt, r_data, r_tgt, r_next;
  logic        r_br, r_jp, r_zr, r_taken;

  initial begin
    vecs[0] = '{32'h00A00093, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         7'h13, 32'h4,         1'b0};
    vecs[1] = '{32'h00000063, 3, 1, 1'b1, 1'b0, 1'b1, 32'h40,        32'h4,         7'h63, 32'h40,        1'b0};
    vecs[2] = '{32'h00000063, 0, 2, 1'b1, 1'b0, 1'b0, 32'h80,        32'h40,        7'h63, 32'h44,        1'b0};
    vecs[3] = '{32'h0000006F, 1, 0, 1'b0, 1'b1, 1'b0, 32'h102,       32'h44,        7'h6F, 32'h100,       1'b1};
    vecs[4] = '{32'h00000063, 2, 0, 1'b1, 1'b0, 1'b1, 32'h203,       32'h100,       7'h63, 32'h200,       1'b1};
    vecs[5] = '{32'h00000033, 0, 1, 1'b0, 1'b0, 1'b1, 32'h10,        32'h200,       7'h33, 32'h204,       1'b0};
    vecs[6] = '{32'h0000006F, 0, 0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h204,       7'h6F, 32'hFFFF_FFFC, 1'b0};
    vecs[7] = '{32'h00000013, 1, 1, 1'b0, 1'b0, 1'b0, 32'h8,         32'hFFFF_FFFC, 7'h13, 32'h0,         1'b0};
    vecs[8] = '{32'h00000067, 0, 0, 1'b1, 1'b1, 1'b0, 32'h21,        32'h0,         7'h67, 32'h20,        1'b1};

    rst = 1'b1; retire = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0; pc_target = '0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk_reset_state("reset");
    @(negedge clk);

    for (int v = 0; v < 9; v++)
      do_txn(vecs[v].rdata, vecs[v].rdy_dly, vecs[v].rsp_dly, v % 3, vecs[v].br, vecs[v].jp,
             vecs[v].zr, vecs[v].tgt, vecs[v].exp_pc, vecs[v].exp_op, vecs[v].exp_next,
             vecs[v].exp_mis, 32'(v + 1));

    // Reset colliding with a retire in S_HOLD.
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rdata = 32'h00000063;
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    chk("hold_before_rst", 32'(instr_valid), 32'd1);
    retire = 1'b1; branch = 1'b0; jump = 1'b1; zero = 1'b0; pc_target = 32'h301; rst = 1'b1;
    @(negedge clk);
    retire = 1'b0; rst = 1'b0;
    #1;
    chk_reset_state("rst_vs_retire");
    @(negedge clk);

    // Reset mid-handshake with a response arriving during and after reset.
    bus.imem_req_ready = 1'b1;
    @(negedge clk);
    bus.imem_req_ready = 1'b0;
    rst = 1'b1;
    bus.imem_rsp_valid = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rst_wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
    bus.imem_rsp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.imem_rsp_valid = 1'b1; bus.imem_rdata = 32'hCAFE_F00D;
    #1;
    chk_reset_state("rst_wait");
    @(negedge clk);
    bus.imem_rsp_valid = 1'b0;
    chk("late_rsp_discarded", 32'(instr_valid), 32'd0);
    chk("late_rsp_instr", instr, 32'h0);
    chk("late_rsp_req_valid", 32'(bus.imem_req_valid), 32'd1);

    m_pc = 32'h0;
    m_cnt = 32'h0;
    for (int n = 0; n < 40; n++) begin
      r_data = $urandom;
      r_br = 1'($urandom); r_jp = 1'($urandom_range(0, 3) == 0); r_zr = 1'($urandom);
      r_tgt = $urandom;
      r_taken = r_jp || (r_br && r_zr);
      r_next = r_taken ? (r_tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
      do_txn(r_data, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 2)), r_br, r_jp, r_zr, r_tgt, m_pc, r_data[6:0], r_next,
             r_taken && (r_tgt % 4 != 0), m_cnt + 32'd1);
      m_pc = r_next;
      m_cnt = m_cnt + 32'd1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
